// File: rtl/acorn128_stream_if.sv
// Word-serial stream front/back end for acorn128_top: loads 16 input words into the
// core operands, runs the core, then streams the result out. Option: ACORN128_STREAM_TAG_EN.
module acorn128_stream_if #(
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid_in,
  output logic         s_ready_out,
  input  logic [31:0]  s_data_in,
  input  logic         s_encrypt_in,
  output logic         core_start_out,
  output logic         core_encrypt_out,
  output logic [127:0] core_key_out,
  output logic [127:0] core_iv_out,
  output logic [127:0] core_ad_out,
  output logic [127:0] core_text_out,
  output logic [63:0]  core_len_out,
  input  logic         core_ready_in,
  input  logic [127:0] core_data_in,
  input  logic [127:0] core_tag_in,
  output logic         m_valid_out,
  input  logic         m_ready_in,
  output logic [31:0]  m_data_out,
  output logic         m_last_out,
  output logic         err_timeout_out
);

`ifdef ACORN128_STREAM_TAG_EN
  localparam int SR_W  = 256;
  localparam int N_OUT = 8;
`else
  localparam int SR_W  = 128;
  localparam int N_OUT = 4;
`endif
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      word_cnt;
  logic [TW-1:0]   run_cnt;
  logic [2:0]      out_cnt;
  logic [SR_W-1:0] shift_reg;
  logic            s_fire;
  logic            m_fire;
  logic            run_capture;
  logic            run_expire;
  logic            out_final;
  logic [6:0]      word_lsb;

  assign core_len_out = 64'd128;
  assign s_fire       = s_valid_in && s_ready_out;
  assign m_fire       = m_valid_out && m_ready_in;
  assign out_final    = (out_cnt == 3'(N_OUT - 1));
  assign m_data_out   = shift_reg[SR_W-1 -: 32];
  assign m_last_out   = m_valid_out && out_final;
  // Word k of a field lands most-significant first, so its LSB is 32*(3-k).
  assign word_lsb     = {~word_cnt[1:0], 5'b0};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    s_ready_out     = 1'b0;
    core_start_out  = 1'b0;
    m_valid_out     = 1'b0;
    err_timeout_out = 1'b0;
    run_capture     = 1'b0;
    run_expire      = 1'b0;
    case (state)
      IDLE: state_next = LOAD;
      LOAD: begin
        s_ready_out = 1'b1;
        if (s_valid_in && word_cnt == 4'd15) state_next = RUN;
      end
      RUN: begin
        core_start_out = 1'b1;
        // A ready seen in the first RUN cycle may belong to the previous block.
        if (run_cnt != '0 && core_ready_in) begin
          run_capture = 1'b1;
          state_next  = DRAIN;
        end else if (run_cnt == TW'(TIMEOUT - 1)) begin
          run_expire      = 1'b1;
          err_timeout_out = 1'b1;
          state_next      = LOAD;
        end
      end
      DRAIN: begin
        m_valid_out = 1'b1;
        if (m_ready_in && out_final) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt         <= '0;
      run_cnt          <= '0;
      out_cnt          <= '0;
      shift_reg        <= '0;
      core_encrypt_out <= 1'b0;
      core_key_out     <= '0;
      core_iv_out      <= '0;
      core_ad_out      <= '0;
      core_text_out    <= '0;
    end else begin
      if (s_fire) begin
        word_cnt <= word_cnt + 4'd1;
        if (word_cnt == 4'd0) core_encrypt_out <= s_encrypt_in;
        case (word_cnt[3:2])
          2'd0:    core_key_out[word_lsb +: 32]  <= s_data_in;
          2'd1:    core_iv_out[word_lsb +: 32]   <= s_data_in;
          2'd2:    core_ad_out[word_lsb +: 32]   <= s_data_in;
          default: core_text_out[word_lsb +: 32] <= s_data_in;
        endcase
      end

      if (state == RUN) run_cnt <= run_cnt + 1'b1;
      else              run_cnt <= '0;

      // An expired block is abandoned entirely so a stale operand set can never be rerun.
      if (run_expire) begin
        word_cnt         <= '0;
        core_encrypt_out <= 1'b0;
        core_key_out     <= '0;
        core_iv_out      <= '0;
        core_ad_out      <= '0;
        core_text_out    <= '0;
      end

      if (run_capture) begin
`ifdef ACORN128_STREAM_TAG_EN
        shift_reg <= {core_data_in, core_tag_in};
`else
        shift_reg <= core_data_in;
`endif
        out_cnt <= '0;
      end else if (m_fire) begin
        shift_reg <= shift_reg << 32;
        out_cnt   <= out_cnt + 3'd1;
        if (out_final) word_cnt <= '0;
      end
    end
  end

`ifndef ACORN128_STREAM_TAG_EN
  logic unused_tag;
  assign unused_tag = ^core_tag_in;
`endif

endmodule

// File: tb/tb_acorn128_stream_if.sv
// Self-checking bench for acorn128_stream_if with a stub core (data = text^key, tag = iv^ad,
// ready 5 cycles after start); expectations come from a field-level reference model.
module tb_acorn128_stream_if;

  localparam int TIMEOUT = 8;
`ifdef ACORN128_STREAM_TAG_EN
  localparam int N_OUT = 8;
`else
  localparam int N_OUT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid_in;
  logic         s_ready_out;
  logic [31:0]  s_data_in;
  logic         s_encrypt_in;
  logic         core_start_out;
  logic         core_encrypt_out;
  logic [127:0] core_key_out;
  logic [127:0] core_iv_out;
  logic [127:0] core_ad_out;
  logic [127:0] core_text_out;
  logic [63:0]  core_len_out;
  logic         core_ready_in;
  logic [127:0] core_data_in;
  logic [127:0] core_tag_in;
  logic         m_valid_out;
  logic         m_ready_in;
  logic [31:0]  m_data_out;
  logic         m_last_out;
  logic         err_timeout_out;

  int checks = 0;
  int passed = 0;

  // Stub core: 0 = ready 5 cycles after start, 1 = ready always high, 2 = never ready.
  int stub_mode = 0;
  int stub_cnt  = 0;

  // Current test vector and collected outputs.
  logic [127:0] k_v, iv_v, ad_v, tx_v;
  logic         enc_v;
  logic [31:0]  got_words [8];
  logic [7:0]   got_last;
  int           got_n;
  int           unstable;
  int           lat;
  int           start_cnt;
  int           load_stuck;

  always #5 clk = ~clk;

  acorn128_stream_if #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_valid_in       (s_valid_in),
    .s_ready_out      (s_ready_out),
    .s_data_in        (s_data_in),
    .s_encrypt_in     (s_encrypt_in),
    .core_start_out   (core_start_out),
    .core_encrypt_out (core_encrypt_out),
    .core_key_out     (core_key_out),
    .core_iv_out      (core_iv_out),
    .core_ad_out      (core_ad_out),
    .core_text_out    (core_text_out),
    .core_len_out     (core_len_out),
    .core_ready_in    (core_ready_in),
    .core_data_in     (core_data_in),
    .core_tag_in      (core_tag_in),
    .m_valid_out      (m_valid_out),
    .m_ready_in       (m_ready_in),
    .m_data_out       (m_data_out),
    .m_last_out       (m_last_out),
    .err_timeout_out  (err_timeout_out)
  );

  always @(posedge clk) begin
    if (rst || !core_start_out) stub_cnt <= 0;
    else                        stub_cnt <= stub_cnt + 1;
  end
  assign core_ready_in = (stub_mode == 1) || (stub_mode == 0 && stub_cnt >= 5);
  assign core_data_in  = core_text_out ^ core_key_out;
  assign core_tag_in   = core_iv_out ^ core_ad_out;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required finish earlier)", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: the 16-word input stream and the expected output stream.
  function automatic logic [31:0] field_word(input logic [127:0] k, iv, ad, tx, input int i);
    logic [511:0] all;
    all = {k, iv, ad, tx};
    return all[511 - 32*i -: 32];
  endfunction

  function automatic logic [31:0] exp_word(input logic [127:0] k, iv, ad, tx, input int j);
    logic [255:0] all;
    all = {tx ^ k, iv ^ ad};
    return all[255 - 32*j -: 32];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the first nwords words with random gaps; returns one sample after the last accept.
  task automatic load_words(input int nwords);
    int guard;
    for (int i = 0; i < nwords; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid_in = 1'b0;
        tick();
      end
      s_valid_in   = 1'b1;
      s_data_in    = field_word(k_v, iv_v, ad_v, tx_v, i);
      s_encrypt_in = (i == 0) ? enc_v : 1'($urandom);
      guard = 0;
      while (!s_ready_out && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) load_stuck++;
      tick();
    end
    s_valid_in = 1'b0;
  endtask

  task automatic wait_result();
    lat       = 0;
    start_cnt = 0;
    while (!m_valid_out && lat < 64) begin
      if (core_start_out) start_cnt++;
      tick();
      lat++;
    end
  endtask

  // bp: 0 = always ready, 1 = toggle starting high, 2 = random.
  task automatic drain(input int bp);
    int          guard;
    logic        hold;
    logic [31:0] prev_data;
    logic        prev_last;
    got_n    = 0;
    got_last = '0;
    unstable = 0;
    guard    = 0;
    hold     = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (got_n < N_OUT && guard < 200) begin
      m_ready_in = (bp == 0) ? 1'b1 : (bp == 1) ? ((guard % 2) == 0) : 1'($urandom);
      if (hold && (m_data_out !== prev_data || m_last_out !== prev_last)) unstable++;
      if (m_valid_out && m_ready_in) begin
        got_words[got_n] = m_data_out;
        got_last[got_n]  = m_last_out;
        got_n++;
        hold = 1'b0;
      end else begin
        hold      = m_valid_out;
        prev_data = m_data_out;
        prev_last = m_last_out;
      end
      tick();
      guard++;
    end
    m_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid_in = 1'b0; s_data_in = '0; s_encrypt_in = 1'b0; m_ready_in = 1'b0;
    tick(); tick();
    checks++;
    if ({s_ready_out, core_start_out, core_encrypt_out, m_valid_out, m_last_out, err_timeout_out,
         m_data_out, core_key_out, core_iv_out, core_ad_out, core_text_out} !== '0)
      $display("FAIL reset_outputs: ready=%b start=%b enc=%b mvalid=%b key=%h, required all zero",
               s_ready_out, core_start_out, core_encrypt_out, m_valid_out, core_key_out);
    else passed++;
    checks++;
    if (core_len_out !== 64'd128) $display("FAIL reset_len: got %0d, required 128", core_len_out);
    else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if (s_ready_out !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", s_ready_out);
    else passed++;
  endtask

  task automatic test_encrypt(input int bp, input int exp_lat, input string tag);
    load_stuck = 0;
    load_words(16);
    checks++;
    if (load_stuck != 0 || core_start_out !== 1'b1)
      $display("FAIL %s_start: start=%b stuck=%0d, required start=1 stuck=0", tag, core_start_out, load_stuck);
    else passed++;
    checks++;
    if ({core_key_out, core_iv_out, core_ad_out, core_text_out} !== {k_v, iv_v, ad_v, tx_v})
      $display("FAIL %s_operands: key=%h iv=%h ad=%h text=%h, required %h %h %h %h", tag,
               core_key_out, core_iv_out, core_ad_out, core_text_out, k_v, iv_v, ad_v, tx_v);
    else passed++;
    checks++;
    if (core_encrypt_out !== enc_v) $display("FAIL %s_mode: got %b, required %b", tag, core_encrypt_out, enc_v);
    else passed++;
    wait_result();
    checks++;
    if (lat != exp_lat || start_cnt != exp_lat || core_start_out !== 1'b0)
      $display("FAIL %s_latency: lat=%0d start_cycles=%0d start=%b, required %0d %0d 0", tag,
               lat, start_cnt, core_start_out, exp_lat, exp_lat);
    else passed++;
    drain(bp);
    checks++;
    if (got_n != N_OUT) $display("FAIL %s_word_count: got %0d, required %0d", tag, got_n, N_OUT);
    else passed++;
    for (int j = 0; j < got_n; j++) begin
      checks++;
      if (got_words[j] !== exp_word(k_v, iv_v, ad_v, tx_v, j))
        $display("FAIL %s_word%0d: got %h, required %h", tag, j, got_words[j], exp_word(k_v, iv_v, ad_v, tx_v, j));
      else passed++;
    end
    checks++;
    if (got_last !== (8'd1 << (N_OUT - 1)))
      $display("FAIL %s_last: got mask %b, required %b", tag, got_last, 8'd1 << (N_OUT - 1));
    else passed++;
    checks++;
    if (unstable != 0) $display("FAIL %s_hold: %0d changes under back-pressure, required 0", tag, unstable);
    else passed++;
    checks++;
    if (m_valid_out !== 1'b0 || s_ready_out !== 1'b1)
      $display("FAIL %s_return_load: mvalid=%b sready=%b, required 0 1", tag, m_valid_out, s_ready_out);
    else passed++;
  endtask

  task automatic test_spec_vector();
    k_v  = 128'h00112233445566778899AABBCCDDEEFF;
    iv_v = 128'h0123456789ABCDEF0123456789ABCDEF;
    ad_v = 128'h11223344556677889900AABBCCDDEEFF;
    tx_v = 128'hAABBCCDDEEFF00112233445566778899;
    enc_v = 1'b1;
    stub_mode = 0;
    test_encrypt(0, 6, "encrypt");
  endtask

  task automatic test_decrypt();
    logic [127:0] plain;
    plain = 128'hAABBCCDDEEFF00112233445566778899;
    tx_v  = plain ^ k_v;
    enc_v = 1'b0;
    test_encrypt(0, 6, "decrypt");
    checks++;
    if ({got_words[0], got_words[1], got_words[2], got_words[3]} !== plain)
      $display("FAIL decrypt_plain: got %h%h%h%h, required %h", got_words[0], got_words[1],
               got_words[2], got_words[3], plain);
    else passed++;
  endtask

  task automatic test_back_pressure();
    k_v = rand128(); iv_v = rand128(); ad_v = rand128(); tx_v = rand128(); enc_v = 1'($urandom);
    stub_mode = 0;
    test_encrypt(1, 6, "backpressure");
  endtask

  task automatic test_stale_ready();
    k_v = rand128(); iv_v = rand128(); ad_v = rand128(); tx_v = rand128(); enc_v = 1'b1;
    stub_mode = 1;
    test_encrypt(0, 2, "stale");
    stub_mode = 0;
  endtask

  task automatic test_timeout();
    int err_cnt, err_at, mv, guard;
    k_v = rand128(); iv_v = rand128(); ad_v = rand128(); tx_v = rand128(); enc_v = 1'b1;
    stub_mode = 2;
    load_words(16);
    start_cnt = 0; err_cnt = 0; err_at = -1; mv = 0; guard = 0;
    while ((core_start_out || start_cnt == 0) && guard < 64) begin
      if (core_start_out) start_cnt++;
      if (err_timeout_out) begin
        err_cnt++;
        err_at = start_cnt;
      end
      if (m_valid_out) mv++;
      tick();
      guard++;
    end
    checks++;
    if (start_cnt != TIMEOUT) $display("FAIL timeout_run_cycles: got %0d, required %0d", start_cnt, TIMEOUT);
    else passed++;
    checks++;
    if (err_cnt != 1 || err_at != TIMEOUT)
      $display("FAIL timeout_pulse: count=%0d at=%0d, required 1 at %0d", err_cnt, err_at, TIMEOUT);
    else passed++;
    checks++;
    if (mv != 0 || m_valid_out !== 1'b0) $display("FAIL timeout_mvalid: got %0d cycles, required 0", mv);
    else passed++;
    checks++;
    if (s_ready_out !== 1'b1 || err_timeout_out !== 1'b0)
      $display("FAIL timeout_reload: sready=%b err=%b, required 1 0", s_ready_out, err_timeout_out);
    else passed++;
    stub_mode = 0;
    k_v = rand128(); iv_v = rand128(); ad_v = rand128(); tx_v = rand128();
    test_encrypt(0, 6, "after_timeout");
  endtask

  task automatic test_reset_mid_load();
    k_v = rand128(); iv_v = rand128(); ad_v = rand128(); tx_v = rand128(); enc_v = 1'b1;
    load_words(7);
    rst = 1'b1;
    tick();
    checks++;
    if ({s_ready_out, core_start_out, core_encrypt_out, m_valid_out, m_last_out, err_timeout_out,
         m_data_out, core_key_out, core_iv_out, core_ad_out, core_text_out} !== '0 || core_len_out !== 64'd128)
      $display("FAIL midreset_outputs: ready=%b enc=%b key=%h iv=%h len=%0d, required zeros and len 128",
               s_ready_out, core_encrypt_out, core_key_out, core_iv_out, core_len_out);
    else passed++;
    rst = 1'b0;
    tick();
    k_v  = {4{32'hEEEEEEEE}};
    iv_v = {4{32'hFFFFFFFF}};
    ad_v = rand128();
    tx_v = {4{32'h66666666}};
    test_encrypt(0, 6, "fresh");
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (got_words[j] !== 32'h88888888) $display("FAIL fresh_result%0d: got %h, required 88888888", j, got_words[j]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      k_v = rand128(); iv_v = rand128(); ad_v = rand128(); tx_v = rand128(); enc_v = 1'($urandom);
      test_encrypt(2, 6, "random");
    end
  endtask

  initial begin
    $display("[TB] start, %0d output words per block", N_OUT);
    test_reset();
    test_spec_vector();
    test_decrypt();
    test_back_pressure();
    test_stale_ready();
    test_timeout();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
